mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. Consumes the 105-bit EX_MEM pipeline register written by the execute stage, performs load/store through a ready-handshaked data-memory port (variable wait states), and registers the 71-bit MEM_WB bundle for write-back. Drives the MEM-side forwarding signals and a stall that freezes all upstream stages while a memory access is outstanding.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Ready-handshaked: a request completes in the cycle dmem_ready is high.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS pipeline memory-access stage: EX_MEM -> data memory -> MEM_WB, with wait-state stall.
// Optional MEM_ALIGN_CHECK_EN suppresses word-misaligned accesses and flags them in MEM_WB[70].
module mem_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [104:0]       EX_MEM,
  mem_stage_if.master        dmem,
  output logic               MEM_Stall,
  output logic               MEM_RegWrite,
  output logic [4:0]         MEM_WriteRegister,
  output logic [31:0]        MEM_RegWriteData,
  output logic [70:0]        MEM_WB
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_stall;
  logic [70:0] r_memWb;
  logic [70:0] w_memWbNext;

  logic [31:0] w_storeData;
  logic [31:0] w_aluResult;
  logic [4:0]  w_writeReg;
  logic        w_memWrite;
  logic        w_regWrite;
  logic [1:0]  w_memtoReg;
  logic [31:0] w_pcPlus4;
  logic        w_isLoad;
  logic        w_access;
  logic        w_misalign;
  logic        w_req;
  logic [31:0] w_wbData;

  assign w_storeData = EX_MEM[31:0];
  assign w_aluResult = EX_MEM[63:32];
  assign w_writeReg  = EX_MEM[68:64];
  assign w_memWrite  = EX_MEM[69];
  assign w_regWrite  = EX_MEM[70];
  assign w_memtoReg  = EX_MEM[72:71];
  assign w_pcPlus4   = EX_MEM[104:73];

  assign w_isLoad = (w_memtoReg == 2'b01);
  assign w_access = w_memWrite | w_isLoad;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & (w_aluResult[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Request is purely combinational; EX_MEM is frozen while stalled so it stays stable.
  assign w_req            = w_access & ~w_misalign;
  assign dmem.dmem_req    = w_req;
  assign dmem.dmem_we     = w_memWrite;
  assign dmem.dmem_addr   = {w_aluResult[31:2], 2'b00};
  assign dmem.dmem_wdata  = w_storeData;

  // Forwarded data for a load is just the address; the hazard unit handles load-use.
  assign MEM_RegWrite      = w_regWrite;
  assign MEM_WriteRegister = w_writeReg;
  assign MEM_RegWriteData  = (w_memtoReg == 2'b10) ? w_pcPlus4 : w_aluResult;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_req && !dmem.dmem_ready) w_nextState = S_WAIT;
      S_WAIT: if (!w_req || dmem.dmem_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_req & ~dmem.dmem_ready;
      S_WAIT:  w_stall = w_req & ~dmem.dmem_ready;
      default: w_stall = 1'b0;
    endcase
  end

  // An abandoned access must not keep upstream frozen while reset is held.
  assign MEM_Stall = w_stall & rst_n;

  always_comb begin
    w_wbData = w_aluResult;
    case (w_memtoReg)
      2'b01:   w_wbData = dmem.dmem_rdata;
      2'b10:   w_wbData = w_pcPlus4;
      default: w_wbData = w_aluResult;
    endcase
  end

  always_comb begin
    w_memWbNext = '0;
    if (!w_stall) begin
      w_memWbNext = {w_misalign, w_pcPlus4, w_regWrite & ~w_misalign, w_writeReg, w_wbData};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memWb <= '0;
    end else begin
      r_memWb <= w_memWbNext;
    end
  end

  assign MEM_WB = r_memWb;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores with wait states, jal, forwarding, reset in WAIT.
module tb_mem_stage;

  logic         clk;
  logic         rst_n;
  logic [104:0] exMem;
  logic         memStall;
  logic         memRegWrite;
  logic [4:0]   memWriteRegister;
  logic [31:0]  memRegWriteData;
  logic [70:0]  memWb;

  int totalChecks;
  int badChecks;

  mem_stage_if dmemBus();

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .EX_MEM            (exMem),
    .dmem              (dmemBus),
    .MEM_Stall         (memStall),
    .MEM_RegWrite      (memRegWrite),
    .MEM_WriteRegister (memWriteRegister),
    .MEM_RegWriteData  (memRegWriteData),
    .MEM_WB            (memWb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [104:0] packEx(input logic [31:0] pc4, input logic [1:0] memtoReg,
                                          input logic regWrite, input logic memWrite,
                                          input logic [4:0] wreg, input logic [31:0] alu,
                                          input logic [31:0] sdata);
    return {pc4, memtoReg, regWrite, memWrite, wreg, alu, sdata};
  endfunction

  function automatic logic [70:0] packWb(input logic mis, input logic [31:0] pc4, input logic rw,
                                         input logic [4:0] wreg, input logic [31:0] data);
    return {mis, pc4, rw, wreg, data};
  endfunction

  task automatic applyStimulus(input logic [104:0] ex, input logic ready, input logic [31:0] rdata);
    exMem = ex;
    dmemBus.dmem_ready = ready;
    dmemBus.dmem_rdata = rdata;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, 32'h0);

    @(negedge clk);
    checkOutput("reset MEM_WB", 128'(memWb), 128'(0));
    checkOutput("reset stall", 128'(memStall), 128'(0));
    checkOutput("reset req", 128'(dmemBus.dmem_req), 128'(0));
    rst_n = 1'b1;

    // ALU result forwarding
    @(negedge clk);
    applyStimulus(packEx(32'h104, 2'b00, 1'b1, 1'b0, 5'd5, 32'h7, 32'h0), 1'b0, 32'h0);
    #1;
    checkOutput("alu fwd rw", 128'(memRegWrite), 128'(1));
    checkOutput("alu fwd reg", 128'(memWriteRegister), 128'(5));
    checkOutput("alu fwd data", 128'(memRegWriteData), 128'(32'h7));
    checkOutput("alu no req", 128'(dmemBus.dmem_req), 128'(0));
    @(posedge clk); #1;
    checkOutput("alu MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h104, 1'b1, 5'd5, 32'h7)));

    // Zero-wait load
    @(negedge clk);
    applyStimulus(packEx(32'h108, 2'b01, 1'b1, 1'b0, 5'd8, 32'h10, 32'h0), 1'b1, 32'hDEADBEEF);
    #1;
    checkOutput("ld req", 128'(dmemBus.dmem_req), 128'(1));
    checkOutput("ld we", 128'(dmemBus.dmem_we), 128'(0));
    checkOutput("ld addr", 128'(dmemBus.dmem_addr), 128'(32'h10));
    checkOutput("ld stall", 128'(memStall), 128'(0));
    checkOutput("ld fwd addr", 128'(memRegWriteData), 128'(32'h10));
    @(posedge clk); #1;
    checkOutput("ld MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h108, 1'b1, 5'd8, 32'hDEADBEEF)));

    // Back-to-back zero-wait load, no idle cycle
    @(negedge clk);
    applyStimulus(packEx(32'h10C, 2'b01, 1'b1, 1'b0, 5'd9, 32'h14, 32'h0), 1'b1, 32'h12345678);
    #1;
    checkOutput("b2b req", 128'(dmemBus.dmem_req), 128'(1));
    checkOutput("b2b stall", 128'(memStall), 128'(0));
    @(posedge clk); #1;
    checkOutput("b2b MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h10C, 1'b1, 5'd9, 32'h12345678)));

    // Store with three wait cycles
    @(negedge clk);
    applyStimulus(packEx(32'h110, 2'b00, 1'b0, 1'b1, 5'd0, 32'h20, 32'h55), 1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("st wait%0d stall", i), 128'(memStall), 128'(1));
      checkOutput($sformatf("st wait%0d bus", i),
                  128'({dmemBus.dmem_req, dmemBus.dmem_we, dmemBus.dmem_addr, dmemBus.dmem_wdata}),
                  128'({1'b1, 1'b1, 32'h20, 32'h55}));
      @(posedge clk); #1;
      checkOutput($sformatf("st wait%0d bubble", i), 128'(memWb), 128'(0));
      @(negedge clk);
    end
    dmemBus.dmem_ready = 1'b1;
    #1;
    checkOutput("st done stall", 128'(memStall), 128'(0));
    checkOutput("st done bus",
                128'({dmemBus.dmem_req, dmemBus.dmem_we, dmemBus.dmem_addr, dmemBus.dmem_wdata}),
                128'({1'b1, 1'b1, 32'h20, 32'h55}));
    @(posedge clk); #1;
    checkOutput("st MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h110, 1'b0, 5'd0, 32'h20)));

    // jal: link address forwarded and written back, no memory access
    @(negedge clk);
    applyStimulus(packEx(32'h400, 2'b10, 1'b1, 1'b0, 5'd31, 32'h1234, 32'h0), 1'b0, 32'h0);
    #1;
    checkOutput("jal req", 128'(dmemBus.dmem_req), 128'(0));
    checkOutput("jal fwd data", 128'(memRegWriteData), 128'(32'h400));
    checkOutput("jal stall", 128'(memStall), 128'(0));
    @(posedge clk); #1;
    checkOutput("jal MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h400, 1'b1, 5'd31, 32'h400)));

    // MemtoReg=11 behaves like ALU result
    @(negedge clk);
    applyStimulus(packEx(32'h500, 2'b11, 1'b1, 1'b0, 5'd3, 32'hABC, 32'h0), 1'b0, 32'h0);
    #1;
    checkOutput("m11 req", 128'(dmemBus.dmem_req), 128'(0));
    checkOutput("m11 fwd", 128'(memRegWriteData), 128'(32'hABC));
    @(posedge clk); #1;
    checkOutput("m11 MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h500, 1'b1, 5'd3, 32'hABC)));

    // Bubble with dmem_ready high: ignored
    @(negedge clk);
    applyStimulus('0, 1'b1, 32'hFACE);
    #1;
    checkOutput("bubble stall", 128'(memStall), 128'(0));
    @(posedge clk); #1;
    checkOutput("bubble MEM_WB", 128'(memWb), 128'(0));

    // Reset asserted during the second wait cycle
    @(negedge clk);
    applyStimulus(packEx(32'h600, 2'b01, 1'b1, 1'b0, 5'd12, 32'h30, 32'h0), 1'b0, 32'h0);
    #1;
    checkOutput("rw wait1 stall", 128'(memStall), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rw stall", 128'(memStall), 128'(0));
    checkOutput("rw MEM_WB", 128'(memWb), 128'(0));
    checkOutput("rw state", 128'(dut.r_state), 128'(0));
    #2;
    rst_n = 1'b1;
    applyStimulus(packEx(32'h604, 2'b01, 1'b1, 1'b0, 5'd13, 32'h34, 32'h0), 1'b1, 32'hCAFEF00D);
    #1;
    checkOutput("post rst stall", 128'(memStall), 128'(0));
    @(posedge clk); #1;
    checkOutput("post rst MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h604, 1'b1, 5'd13, 32'hCAFEF00D)));

    // Misaligned load at 0x12
    @(negedge clk);
    applyStimulus(packEx(32'h700, 2'b01, 1'b1, 1'b0, 5'd7, 32'h12, 32'h0), 1'b1, 32'h0BADF00D);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("mis req", 128'(dmemBus.dmem_req), 128'(0));
    checkOutput("mis stall", 128'(memStall), 128'(0));
    @(posedge clk); #1;
    checkOutput("mis MEM_WB", 128'(memWb), 128'(packWb(1'b1, 32'h700, 1'b0, 5'd7, 32'h0BADF00D)));
`else
    checkOutput("mis req", 128'(dmemBus.dmem_req), 128'(1));
    checkOutput("mis addr", 128'(dmemBus.dmem_addr), 128'(32'h10));
    @(posedge clk); #1;
    checkOutput("mis MEM_WB", 128'(memWb), 128'(packWb(1'b0, 32'h700, 1'b1, 5'd7, 32'h0BADF00D)));
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
